// File: rtl/gtx_align_insert.sv
// Transmit-side ALIGNP inserter for the SATA host PHY.
// Injects periodic (and on-request) ALIGNP bursts on dword boundaries and back-pressures the link layer.
module gtx_align_insert #(
  parameter int ALIGN_PERIOD = 256,
  parameter int ALIGN_COUNT  = 2
) (
  input  logic        wclk,
  input  logic        rst,
  input  logic        en,
  input  logic        align_req,
  input  logic [15:0] data_in,
  input  logic [1:0]  charisk_in,
  output logic        ready_out,
  output logic [15:0] data_out,
  output logic [1:0]  charisk_out,
  output logic        lword_strobe,
  output logic        align_strobe
);

  localparam int W = $clog2(2 * ALIGN_PERIOD);
  localparam logic [W-1:0] BURST_WORDS = W'(2 * ALIGN_COUNT);

  localparam logic [15:0] ALIGN_D0 = 16'h4ABC;
  localparam logic [1:0]  ALIGN_K0 = 2'b01;
  localparam logic [15:0] ALIGN_D1 = 16'h7B4A;
  localparam logic [1:0]  ALIGN_K1 = 2'b00;

  logic [W-1:0] wcnt;
  logic         pending;
  logic         in_burst;
  logic         restart;
  logic         insert;

  assign in_burst  = wcnt < BURST_WORDS;
  // A latched request only fires on a dword boundary so primitives are never split.
  assign restart   = pending & ~wcnt[0];
  assign insert    = in_burst | restart;
  assign ready_out = rst & (~en | ~insert);

  // NOTE: reset is synchronous (sampled on wclk); all state uses non-blocking assignments.
  always_ff @(posedge wclk) begin
    if (!rst) begin
      wcnt         <= '0;
      pending      <= 1'b0;
      data_out     <= '0;
      charisk_out  <= '0;
      lword_strobe <= 1'b0;
      align_strobe <= 1'b0;
    end else if (!en) begin
      wcnt         <= '0;
      pending      <= 1'b0;
      data_out     <= data_in;
      charisk_out  <= charisk_in;
      lword_strobe <= 1'b0;
      align_strobe <= 1'b0;
    end else begin
      lword_strobe <= wcnt[0];
      if (restart) begin
        // Restart the window so the forced burst carries the full ALIGN_COUNT dwords.
        data_out     <= ALIGN_D0;
        charisk_out  <= ALIGN_K0;
        align_strobe <= 1'b1;
        wcnt         <= W'(1);
        pending      <= align_req;
      end else if (in_burst) begin
        data_out     <= wcnt[0] ? ALIGN_D1 : ALIGN_D0;
        charisk_out  <= wcnt[0] ? ALIGN_K1 : ALIGN_K0;
        align_strobe <= ~wcnt[0];
        wcnt         <= wcnt + W'(1);
      end else begin
        data_out     <= data_in;
        charisk_out  <= charisk_in;
        align_strobe <= 1'b0;
        wcnt         <= wcnt + W'(1);
        pending      <= pending | align_req;
      end
    end
  end

endmodule
